// File: rtl/spi_write_target.sv
// SPI mode-0 write target: oversamples SCK/CS_N/MOSI in the clk domain and turns
// command/address/data frames into single-cycle register-write strobes.
//
// state  | meaning
// IDLE   | no frame in progress, waiting for a CS_N fall
// CMD    | receiving the command byte
// ADDR   | receiving the start address byte
// DATA   | receiving data bytes, one write strobe per byte
// IGNORE | frame with an unknown command, discard until CS_N rises
module spi_write_target #(
    parameter int unsigned ADDR_W    = 8,
    parameter logic [7:0]  CMD_WRITE = 8'h02
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              err_cmd
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        IGNORE
    } state_t;

    state_t state_q, state_d;

    logic sclk_s1, sclk_s2, sclk_s3;
    logic cs_s1, cs_s2, cs_s3;
    logic mosi_s1, mosi_s2, mosi_s3;
    logic sck_rise_q, sck_fall_q, cs_rise_q, cs_fall_q;
    logic [1:0] settle_cnt;
    logic cs_armed;

    logic [7:0]        shift_q;
    logic [7:0]        tx_q;
    logic [2:0]        bit_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        rx_byte;
    logic              byte_done;

    logic clr_bits, clr_err, set_err, load_addr, do_write;

    // Edge pulses are registered so every detection lands 3 clk after the pin
    // edge; mosi_s3 keeps the data bit aligned with the SCK rise pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_s1    <= 1'b0;
            sclk_s2    <= 1'b0;
            sclk_s3    <= 1'b0;
            cs_s1      <= 1'b1;
            cs_s2      <= 1'b1;
            cs_s3      <= 1'b1;
            mosi_s1    <= 1'b0;
            mosi_s2    <= 1'b0;
            mosi_s3    <= 1'b0;
            sck_rise_q <= 1'b0;
            sck_fall_q <= 1'b0;
            cs_rise_q  <= 1'b0;
            cs_fall_q  <= 1'b0;
            settle_cnt <= 2'd3;
            cs_armed   <= 1'b0;
        end else begin
            sclk_s1    <= spi_sclk;
            sclk_s2    <= sclk_s1;
            sclk_s3    <= sclk_s2;
            cs_s1      <= spi_cs_n;
            cs_s2      <= cs_s1;
            cs_s3      <= cs_s2;
            mosi_s1    <= spi_mosi;
            mosi_s2    <= mosi_s1;
            mosi_s3    <= mosi_s2;
            sck_rise_q <= sclk_s2 & ~sclk_s3;
            sck_fall_q <= ~sclk_s2 & sclk_s3;
            cs_rise_q  <= cs_s2 & ~cs_s3;
            cs_fall_q  <= cs_armed & ~cs_s2 & cs_s3;
            // A CS_N fall only counts once CS_N has been seen high after the
            // synchroniser flushed its reset value; a frame already in flight at
            // reset release is therefore skipped.
            if (settle_cnt != 2'd0) begin
                settle_cnt <= settle_cnt - 2'd1;
            end else if (cs_s3) begin
                cs_armed <= 1'b1;
            end
        end
    end

    assign rx_byte   = {shift_q[6:0], mosi_s3};
    assign byte_done = sck_rise_q && (state_q != IDLE) && (bit_cnt == 3'd7);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_bits  = 1'b0;
        clr_err   = 1'b0;
        set_err   = 1'b0;
        load_addr = 1'b0;
        do_write  = 1'b0;
        if (cs_rise_q) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cs_fall_q) begin
                        state_d  = CMD;
                        clr_bits = 1'b1;
                        clr_err  = 1'b1;
                    end
                end
                CMD: begin
                    if (byte_done) begin
                        if (rx_byte == CMD_WRITE) begin
                            state_d = ADDR;
                        end else begin
                            state_d = IGNORE;
                            set_err = 1'b1;
                        end
                    end
                end
                ADDR: begin
                    if (byte_done) begin
                        load_addr = 1'b1;
                        state_d   = DATA;
                    end
                end
                DATA: begin
                    if (byte_done) begin
                        do_write = 1'b1;
                    end
                end
                IGNORE: begin
                    state_d = IGNORE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q <= 8'h00;
            bit_cnt <= 3'd0;
        end else if (clr_bits) begin
            shift_q <= 8'h00;
            bit_cnt <= 3'd0;
        end else if (sck_rise_q && (state_q != IDLE)) begin
            shift_q <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    // The fall right after the 8th rise must not shift, otherwise the freshly
    // loaded MSB would be gone before the initiator samples it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_q <= 8'h00;
        end else if (clr_bits) begin
            tx_q <= 8'h00;
        end else if (byte_done && !cs_rise_q) begin
            tx_q <= rx_byte;
        end else if (sck_fall_q && (state_q != IDLE) && (bit_cnt != 3'd0)) begin
            tx_q <= {tx_q[6:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= 8'h00;
        end else begin
            wr_en <= 1'b0;
            if (load_addr) begin
                addr_q <= rx_byte[ADDR_W-1:0];
            end
            if (do_write) begin
                wr_en   <= 1'b1;
                wr_addr <= addr_q;
                wr_data <= rx_byte;
                addr_q  <= addr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cmd <= 1'b0;
        end else if (clr_err) begin
            err_cmd <= 1'b0;
        end else if (set_err) begin
            err_cmd <= 1'b1;
        end
    end

    assign busy     = (state_q != IDLE);
    assign spi_miso = busy & tx_q[7];

endmodule

// File: tb/tb_spi_write_target.sv
// Bench for spi_write_target: bit-bangs SPI frames from the initiator side and
// compares write strobes, flags and MISO echo against a frame-level model.
module tb_spi_write_target;

    localparam logic [7:0] CMD_WRITE = 8'h02;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       spi_sclk = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       spi_mosi = 1'b0;
    logic       spi_miso;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       err_cmd;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_rise_cyc = 0;
    logic [15:0] obs_q[$];
    int          obs_cyc_q[$];
    logic [15:0] last_wr = 16'h0000;

    spi_write_target #(.ADDR_W(8), .CMD_WRITE(CMD_WRITE)) dut (
        .clk      (clk),
        .reset    (reset),
        .spi_sclk (spi_sclk),
        .spi_cs_n (spi_cs_n),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .err_cmd  (err_cmd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (wr_en === 1'b1) begin
            obs_q.push_back({wr_addr, wr_data});
            obs_cyc_q.push_back(cyc);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SPI bit per iteration: MOSI changes with SCK low, MISO is sampled
    // right before the rise, as a mode-0 initiator would.
    task automatic spi_bits(input logic [7:0] b, input int nbits, input int half,
                            output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = b[7-i];
            tick(half);
            rx = {rx[6:0], spi_miso};
            spi_sclk = 1'b1;
            last_rise_cyc = cyc;
            tick(half);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic run_frame(input logic [7:0] fb[$], input int half, input int setup,
                             input int tail, output logic [7:0] echo[$]);
        logic [7:0] rx;
        echo = {};
        spi_cs_n = 1'b0;
        if (setup > half) tick(setup - half);
        foreach (fb[i]) begin
            spi_bits(fb[i], 8, half, rx);
            echo.push_back(rx);
        end
        if (tail > 0) spi_bits(8'($urandom), tail, half, rx);
        tick(3);
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        tick(8);
    endtask

    // Frame-level reference: a write frame writes every complete data byte to
    // consecutive addresses starting at the address byte, wrapping at 256.
    function automatic void model_writes(input logic [7:0] fb[$], output logic [15:0] exp[$]);
        logic [7:0] a;
        exp = {};
        if (fb.size() >= 3 && fb[0] == CMD_WRITE) begin
            for (int k = 2; k < fb.size(); k++) begin
                a = fb[1] + 8'(k - 2);
                exp.push_back({a, fb[k]});
            end
        end
    endfunction

    task automatic test_reset();
        tick(3);
        checks++;
        if ({wr_en, wr_addr, wr_data, busy, err_cmd, spi_miso} !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {wr_en, wr_addr, wr_data, busy, err_cmd, spi_miso});
        end
        reset = 1'b0;
        tick(10);
    endtask

    task automatic test_single_write();
        logic [7:0] fb[$];
        logic [7:0] echo[$];
        logic [7:0] rx;
        fb = {8'h02, 8'h10, 8'hA5};
        obs_q.delete();
        obs_cyc_q.delete();
        echo = {};
        spi_cs_n = 1'b0;
        tick(3);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_early: got %b expected 0", busy); end
        tick(1);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_rise: got %b expected 1", busy); end
        foreach (fb[i]) begin
            spi_bits(fb[i], 8, 4, rx);
            echo.push_back(rx);
        end
        tick(3);
        spi_cs_n = 1'b1;
        tick(3);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_hold: got %b expected 1", busy); end
        tick(1);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_fall: got %b expected 0", busy); end
        tick(6);
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== 16'h10A5) begin
            errors++;
            $display("FAIL single_write: got %0d writes first %h expected 1 write 10a5",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 16'hxxxx);
        end
        checks++;
        if (err_cmd !== 1'b0) begin errors++; $display("FAIL single_err: got %b expected 0", err_cmd); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (echo[i] !== ((i == 0) ? 8'h00 : fb[i-1])) begin
                errors++;
                $display("FAIL single_echo[%0d]: got %h expected %h", i, echo[i],
                         (i == 0) ? 8'h00 : fb[i-1]);
            end
        end
        last_wr = 16'h10A5;
    endtask

    task automatic test_burst_wrap();
        logic [7:0] fb[$];
        logic [7:0] echo[$];
        logic [15:0] exp[$];
        logic [7:0] exp_echo[$];
        fb = {8'h02, 8'hFE, 8'h11, 8'h22, 8'h33};
        exp = {16'hFE11, 16'hFF22, 16'h0033};
        exp_echo = {8'h00, 8'h02, 8'hFE, 8'h11, 8'h22};
        obs_q.delete();
        run_frame(fb, 4, 8, 0, echo);
        checks++;
        if (obs_q.size() != exp.size()) begin
            errors++;
            $display("FAIL burst_count: got %0d writes expected %0d", obs_q.size(), exp.size());
        end else begin
            foreach (exp[i]) begin
                checks++;
                if (obs_q[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL burst_write[%0d]: got %h expected %h", i, obs_q[i], exp[i]);
                end
            end
        end
        foreach (exp_echo[i]) begin
            checks++;
            if (echo[i] !== exp_echo[i]) begin
                errors++;
                $display("FAIL burst_echo[%0d]: got %h expected %h", i, echo[i], exp_echo[i]);
            end
        end
        checks++;
        if ({wr_addr, wr_data} !== 16'h0033) begin
            errors++;
            $display("FAIL burst_hold: got %h expected 0033", {wr_addr, wr_data});
        end
        last_wr = 16'h0033;
    endtask

    task automatic test_bad_cmd();
        logic [7:0] fb[$];
        logic [7:0] echo[$];
        logic [7:0] rx;
        obs_q.delete();
        spi_cs_n = 1'b0;
        tick(4);
        spi_bits(8'h03, 8, 4, rx);
        tick(1);
        checks++;
        if (err_cmd !== 1'b1) begin errors++; $display("FAIL bad_err_early: got %b expected 1", err_cmd); end
        spi_bits(8'h10, 8, 4, rx);
        spi_bits(8'h55, 8, 4, rx);
        tick(3);
        spi_cs_n = 1'b1;
        tick(8);
        checks++;
        if (err_cmd !== 1'b1) begin errors++; $display("FAIL bad_err_sticky: got %b expected 1", err_cmd); end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL bad_no_write: got %0d writes expected 0", obs_q.size());
        end
        fb = {8'h02, 8'h01, 8'h77};
        run_frame(fb, 4, 6, 0, echo);
        checks++;
        if (err_cmd !== 1'b0) begin errors++; $display("FAIL bad_err_clear: got %b expected 0", err_cmd); end
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== 16'h0177) begin
            errors++;
            $display("FAIL bad_next_write: got %0d writes first %h expected 1 write 0177",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 16'hxxxx);
        end
        last_wr = 16'h0177;
    endtask

    task automatic test_abort();
        logic [7:0] fb[$];
        logic [7:0] echo[$];
        obs_q.delete();
        fb = {8'h02, 8'h20};
        run_frame(fb, 4, 6, 4, echo);
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL abort_no_write: got %0d writes expected 0", obs_q.size());
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        fb = {8'h02, 8'h40, 8'hC3};
        run_frame(fb, 4, 6, 0, echo);
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== 16'h40C3) begin
            errors++;
            $display("FAIL abort_next_write: got %0d writes first %h expected 1 write 40c3",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 16'hxxxx);
        end
        last_wr = 16'h40C3;
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] fb[$];
        logic [7:0] echo[$];
        logic [7:0] rx;
        obs_q.delete();
        spi_cs_n = 1'b0;
        tick(4);
        spi_bits(8'h02, 8, 4, rx);
        spi_bits(8'h66, 4, 4, rx);
        reset = 1'b1;
        #1;
        checks++;
        if ({wr_en, wr_addr, wr_data, busy, err_cmd, spi_miso} !== 20'h0) begin
            errors++;
            $display("FAIL midreset_outputs: got %h expected 0",
                     {wr_en, wr_addr, wr_data, busy, err_cmd, spi_miso});
        end
        tick(2);
        reset = 1'b0;
        spi_bits(8'h66, 4, 4, rx);
        spi_bits(8'h99, 8, 4, rx);
        spi_bits(8'h88, 8, 4, rx);
        tick(3);
        spi_cs_n = 1'b1;
        tick(8);
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL midreset_no_write: got %0d writes expected 0", obs_q.size());
        end
        fb = {8'h02, 8'h33, 8'h44};
        run_frame(fb, 4, 6, 0, echo);
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== 16'h3344) begin
            errors++;
            $display("FAIL midreset_next_write: got %0d writes first %h expected 1 write 3344",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 16'hxxxx);
        end
        last_wr = 16'h3344;
    endtask

    task automatic test_timing_edge();
        logic [7:0] fb[$];
        logic [7:0] echo[$];
        obs_q.delete();
        obs_cyc_q.delete();
        fb = {8'h02, 8'h5A, 8'h3C};
        run_frame(fb, 2, 3, 0, echo);
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== 16'h5A3C) begin
            errors++;
            $display("FAIL fast_write: got %0d writes first %h expected 1 write 5a3c",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 16'hxxxx);
        end else begin
            checks++;
            if (obs_cyc_q[0] != last_rise_cyc + 4) begin
                errors++;
                $display("FAIL fast_latency: got %0d clk after last SCK rise expected 4",
                         obs_cyc_q[0] - last_rise_cyc);
            end
        end
        last_wr = 16'h5A3C;
    endtask

    task automatic test_random();
        for (int f = 0; f < 24; f++) begin
            logic [7:0] fb[$];
            logic [7:0] echo[$];
            logic [15:0] exp[$];
            int half;
            int setup;
            int tail;
            int ndata;
            fb = {};
            if ($urandom_range(0, 4) == 0) fb.push_back(CMD_WRITE ^ 8'($urandom_range(1, 255)));
            else fb.push_back(CMD_WRITE);
            fb.push_back(8'($urandom));
            ndata = $urandom_range(0, 3);
            for (int k = 0; k < ndata; k++) fb.push_back(8'($urandom));
            half  = $urandom_range(2, 4);
            setup = 3 + $urandom_range(0, 3);
            tail  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            obs_q.delete();
            run_frame(fb, half, setup, tail, echo);
            model_writes(fb, exp);
            checks++;
            if (obs_q.size() != exp.size()) begin
                errors++;
                $display("FAIL rand%0d_count: got %0d writes expected %0d", f, obs_q.size(), exp.size());
            end else begin
                foreach (exp[i]) begin
                    checks++;
                    if (obs_q[i] !== exp[i]) begin
                        errors++;
                        $display("FAIL rand%0d_write[%0d]: got %h expected %h", f, i, obs_q[i], exp[i]);
                    end
                end
            end
            checks++;
            if (err_cmd !== (fb[0] != CMD_WRITE)) begin
                errors++;
                $display("FAIL rand%0d_err: got %b expected %b", f, err_cmd, fb[0] != CMD_WRITE);
            end
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL rand%0d_busy: got %b expected 0", f, busy); end
            if (exp.size() > 0) last_wr = exp[exp.size()-1];
            checks++;
            if ({wr_addr, wr_data} !== last_wr) begin
                errors++;
                $display("FAIL rand%0d_hold: got %h expected %h", f, {wr_addr, wr_data}, last_wr);
            end
            if (half == 4) begin
                foreach (echo[i]) begin
                    checks++;
                    if (echo[i] !== ((i == 0) ? 8'h00 : fb[i-1])) begin
                        errors++;
                        $display("FAIL rand%0d_echo[%0d]: got %h expected %h", f, i, echo[i],
                                 (i == 0) ? 8'h00 : fb[i-1]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_burst_wrap();
        test_bad_cmd();
        test_abort();
        test_reset_mid_frame();
        test_timing_edge();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_write_target.md
# spi_write_target

SPI mode-0 target that receives SPI write cycles from the board's SPI initiator and turns them into parallel register-write strobes. Frame format is command byte, address byte, then one or more data bytes, all MSB first. SCK, CS_N and MOSI are oversampled in the `clk` domain. The block sits between the external SPI pins and the local register file.

## Interface
Parameters:
- `ADDR_W`, default 8: register address width, legal range 1..8; the low `ADDR_W` bits of the address byte are used.
- `CMD_WRITE`, default 8'h02: command byte that opens a write cycle.

Ports:
- `clk`, input, 1: system clock.
- `reset`, input, 1: asynchronous, active-high reset.
- `spi_sclk`, input, 1: SPI clock, asynchronous to `clk`; idles low (mode 0).
- `spi_cs_n`, input, 1: chip select, active low, asynchronous.
- `spi_mosi`, input, 1: serial data in, sampled on SCK rising edges.
- `spi_miso`, output, 1: serial data out, updated on SCK falling edges.
- `wr_en`, output, 1: one-`clk` write strobe.
- `wr_addr`, output, `ADDR_W`: write address, valid while `wr_en` is high.
- `wr_data`, output, 8: write data, valid while `wr_en` is high.
- `busy`, output, 1: a frame is in progress (state != IDLE).
- `err_cmd`, output, 1: sticky flag; the last frame carried a command other than `CMD_WRITE`.

## Operation
- Synchronisation:
  - `spi_sclk`, `spi_cs_n` and `spi_mosi` each pass through a 2-flop synchroniser.
  - A third flop on SCK and on CS_N provides edge detection.
  - The synchroniser flops reset to: SCK 0, CS_N 1, MOSI 0.
- Bit capture:
  - On a detected SCK rise while CS_N is low, shift the synchronised MOSI into the LSB of an 8-bit shift register.
  - Increment a 3-bit bit counter on each such rise.
  - The byte is complete when the counter wraps from 7 to 0.
- State machine (IDLE, CMD, ADDR, DATA, IGNORE):
  - IDLE -> CMD on a detected CS_N fall. On this transition: bit counter is cleared, `err_cmd` is cleared, `busy` is set.
  - CMD, at byte complete: if byte == `CMD_WRITE`, go to ADDR; otherwise go to IGNORE and set `err_cmd`.
  - ADDR, at byte complete: load the address counter with `byte[ADDR_W-1:0]` and go to DATA.
  - DATA, at byte complete: pulse `wr_en` with `wr_addr` = address counter and `wr_data` = byte. Then increment the address counter modulo 2^`ADDR_W` (0xFF wraps to 0x00 when `ADDR_W`=8). Stay in DATA.
  - IGNORE: discard all bits.
  - Any state -> IDLE on a detected CS_N rise. A partial byte is discarded and produces no `wr_en`. The address counter keeps its value. `err_cmd` holds.
- MISO:
  - `spi_miso` shifts out a transmit byte MSB first.
  - The transmit byte is loaded at byte complete with the byte just received, so the initiator sees each byte echoed one byte late.
  - During CMD the transmit byte is 0x00.
  - The first bit of each byte is presented when the byte is loaded. The remaining bits advance on detected SCK falls.
  - `spi_miso` is 0 in IDLE.
- Simultaneous events:
  - A CS_N rise detected in the same cycle as byte complete takes priority: no `wr_en`, go to IDLE.
  - A CS_N fall detected while not in IDLE is impossible without an intervening rise and needs no handling.
- Reset:
  - Any state, any time -> IDLE.
  - All outputs 0 (`wr_en`, `wr_addr`, `wr_data`, `busy`, `err_cmd`, `spi_miso`).
  - The shift register, bit counter and address counter are cleared.
  - If CS_N is already low when reset releases, no CS_N fall is seen, so the rest of that frame is ignored. Decoding resumes at the next CS_N fall.

## Timing
- SCK frequency must not exceed `clk`/4. Each SCK high and low phase lasts at least 2 `clk` periods.
- CS_N fall to first SCK rise: at least 3 `clk` periods.
- Last SCK fall to CS_N rise: at least 3 `clk` periods.
- A pin edge is detected 3 `clk` cycles after it occurs (2 synchroniser flops plus 1 edge flop).
- `wr_en` rises on the `clk` edge following the detection cycle of the 8th SCK rise of a data byte, i.e. 4 `clk` after the pin edge. It is high for exactly 1 cycle.
- `wr_addr` and `wr_data` hold their values until the next `wr_en`.
- `busy` rises 4 `clk` after the CS_N pin falls and falls 4 `clk` after the CS_N pin rises.
- Back-to-back data bytes produce one `wr_en` per byte. There is no stall and no backpressure.

## Test plan
- Single write, SCK at `clk`/8: frame 0x02, 0x10, 0xA5 -> exactly one `wr_en`, `wr_addr`=0x10, `wr_data`=0xA5. `busy` low after CS_N rises; `err_cmd`=0.
- Burst with wrap: frame 0x02, 0xFE, then 0x11, 0x22, 0x33 -> three `wr_en` pulses at addresses 0xFE, 0xFF, 0x00 with data 0x11, 0x22, 0x33. MISO returns 0x00, 0x02, 0xFE, 0x11, 0x22.
- Bad command: frame 0x03, 0x10, 0x55 -> no `wr_en`, `err_cmd`=1 after the first byte and still 1 after CS_N rises. The next frame 0x02, 0x01, 0x77 clears `err_cmd` and writes 0x77 to 0x01.
- Abort: frame 0x02, 0x20, then 4 bits only, then CS_N rises -> no `wr_en`, `busy`=0, and the next valid frame decodes correctly.
- Reset mid-frame: assert `reset` during the address byte while CS_N is low -> all outputs 0 immediately. The remaining bytes of that frame produce no `wr_en`. The next frame writes correctly.
- Timing edge: SCK at `clk`/4 with a 3-cycle CS_N setup -> all bits captured. `wr_en` occurs 4 `clk` after the 8th SCK pin rise of the data byte.
